fpu_ret_arb: RTL and testbench

FPU_RET_ARB -- requirements
Module: fpu_ret_arb

---
 rtl/fpu_ret_pkg.sv | 15 +
 rtl/fpu_ret_arb_if.sv | 41 ++++
 rtl/fpu_ret_fifo.sv | 56 +++++
 rtl/fpu_ret_arb.sv | 139 +++++++++++++
 tb/tb_fpu_ret_arb.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fpu_ret_pkg.sv
// Shared definitions for the FP return arbiter: default return-code width
// and the source-port identifiers carried on the retire bus.
package fpu_ret_pkg;

    localparam int unsigned RETW_DEF  = 14;
    localparam int unsigned NUM_PORTS = 3;

    // Source port id as driven on out_port; encoding 3 is never used.
    typedef enum logic [1:0] {
        PORT_U1 = 2'd0,
        PORT_U3 = 2'd1,
        PORT_U5 = 2'd2
    } port_id_t;

endpackage

// File: rtl/fpu_ret_arb_if.sv
// Bus bundle between the FP return ports, the scheduler throttles and the
// retire bus.
//   master: FP units / scheduler / retire bus side (drives ret_en, ret, out_rdy)
//   slave : arbiter side (drives stalls, out_vld, out_data, out_port, ovf)
interface fpu_ret_arb_if
    import fpu_ret_pkg::*;
#(
    parameter int unsigned RETW = RETW_DEF
);
    logic            u1_ret_en;
    logic            u3_ret_en;
    logic            u5_ret_en;
    logic [RETW-1:0] u1_ret;
    logic [RETW-1:0] u3_ret;
    logic [RETW-1:0] u5_ret;
    logic            u1_stall;
    logic            u3_stall;
    logic            u5_stall;
    logic            out_vld;
    logic [RETW-1:0] out_data;
    logic [1:0]      out_port;
    logic            out_rdy;
    logic [2:0]      ovf;

    modport master (
        output u1_ret_en, u3_ret_en, u5_ret_en,
        output u1_ret, u3_ret, u5_ret,
        output out_rdy,
        input  u1_stall, u3_stall, u5_stall,
        input  out_vld, out_data, out_port, ovf
    );

    modport slave (
        input  u1_ret_en, u3_ret_en, u5_ret_en,
        input  u1_ret, u3_ret, u5_ret,
        input  out_rdy,
        output u1_stall, u3_stall, u5_stall,
        output out_vld, out_data, out_port, ovf
    );

endinterface

// File: rtl/fpu_ret_fifo.sv
// Per-port return FIFO. A push to a full FIFO is accepted only when a pop
// happens in the same cycle; otherwise it is dropped and contents are kept.
//   clk, rst : clock, async active-high reset
//   push/din : write request and data
//   pop      : remove head (ignored when empty)
//   head     : current head entry
//   count    : occupancy, $clog2(DEPTH)+1 bits
//   full     : count == DEPTH
module fpu_ret_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr;
    logic          rd;

    assign full = (count == CW'(DEPTH));
    assign wr   = push && (!full || pop);
    assign rd   = pop && (count != '0);
    assign head = mem[rptr];

    // Storage carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + AW'(1);
            if (rd) rptr <= rptr + AW'(1);
            count <= count + CW'(wr) - CW'(rd);
        end
    end

endmodule

// File: rtl/fpu_ret_arb.sv
// Merges return codes from FP ports u1/u3/u5 onto one retire bus.
// Each port is buffered in a FIFO; non-empty heads are arbitrated
// round-robin into a registered output stage with valid/ready handshake.
//   clk, rst : clock, async active-high reset
//   bus      : fpu_ret_arb_if.slave (ret_en/ret in, stalls, out_*, ovf)
// Optional macro FPU_RET_ARB_BYPASS_EN: an empty FIFO's incoming code may be
// granted directly into the output register (latency 1 instead of 2).
module fpu_ret_arb
    import fpu_ret_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned RETW  = RETW_DEF
) (
    input  logic         clk,
    input  logic         rst,
    fpu_ret_arb_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned NP = NUM_PORTS;

    logic [NP-1:0]   ret_en;
    logic [RETW-1:0] ret       [NP];
    logic [RETW-1:0] head      [NP];
    logic [CW-1:0]   count     [NP];
    logic [CW-1:0]   count_nxt [NP];
    logic [NP-1:0]   full;
    logic [NP-1:0]   empty;
    logic [NP-1:0]   cand;
    logic [NP-1:0]   sel;
    logic [NP-1:0]   byp;
    logic [NP-1:0]   push;
    logic [NP-1:0]   pop;
    logic [NP-1:0]   push_ok;
    logic [NP-1:0]   ovf_set;

    logic            load;
    logic            gnt_vld;
    port_id_t        gnt;
    logic [2:0]      idx;
    logic [RETW-1:0] gnt_data;

    logic            out_vld_q;
    logic [RETW-1:0] out_data_q;
    port_id_t        out_port_q;
    port_id_t        last_q;
    logic [NP-1:0]   ovf_q;
    logic [NP-1:0]   stall_q;

    assign ret_en = {bus.u5_ret_en, bus.u3_ret_en, bus.u1_ret_en};
    assign ret[0] = bus.u1_ret;
    assign ret[1] = bus.u3_ret;
    assign ret[2] = bus.u5_ret;

    // Output register may take a new entry when empty or being accepted.
    assign load = !out_vld_q || bus.out_rdy;

`ifdef FPU_RET_ARB_BYPASS_EN
    assign cand     = ~empty | ret_en;
    assign gnt_data = empty[gnt] ? ret[gnt] : head[gnt];
    assign byp      = sel & empty;
`else
    assign cand     = ~empty;
    assign gnt_data = head[gnt];
    assign byp      = '0;
`endif

    // Round-robin: scan last+3 .. last+1 so the port right after last wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = PORT_U1;
        idx     = '0;
        for (int k = 3; k >= 1; k--) begin
            idx = 3'(last_q) + 3'(k);
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (cand[idx[1:0]]) begin
                gnt_vld = 1'b1;
                gnt     = port_id_t'(idx[1:0]);
            end
        end
    end

    assign sel     = (load && gnt_vld) ? (3'b001 << gnt) : '0;
    assign pop     = sel & ~empty;
    assign push    = ret_en & ~byp;
    assign push_ok = push & (~full | pop);
    assign ovf_set = push & full & ~pop;

    for (genvar i = 0; i < NP; i++) begin : g_port
        fpu_ret_fifo #(
            .DEPTH (DEPTH),
            .W     (RETW)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (ret[i]),
            .head  (head[i]),
            .count (count[i]),
            .full  (full[i])
        );
        assign empty[i]     = (count[i] == '0);
        assign count_nxt[i] = count[i] + CW'(push_ok[i]) - CW'(pop[i]);
    end

    // Output stage, round-robin pointer, sticky overflow and stall flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_port_q <= PORT_U1;
            last_q     <= PORT_U5;
            ovf_q      <= '0;
            stall_q    <= '0;
        end else begin
            ovf_q <= ovf_q | ovf_set;
            for (int i = 0; i < 3; i++) begin
                stall_q[i] <= (count_nxt[i] >= CW'(DEPTH - 2));
            end
            if (load) begin
                out_vld_q <= gnt_vld;
                if (gnt_vld) begin
                    out_data_q <= gnt_data;
                    out_port_q <= gnt;
                    last_q     <= gnt;
                end
            end
        end
    end

    assign bus.out_vld  = out_vld_q;
    assign bus.out_data = out_data_q;
    assign bus.out_port = out_port_q;
    assign bus.ovf      = ovf_q;
    assign bus.u1_stall = stall_q[0];
    assign bus.u3_stall = stall_q[1];
    assign bus.u5_stall = stall_q[2];

endmodule

// File: tb/tb_fpu_ret_arb.sv
// Self-checking bench for fpu_ret_arb: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_fpu_ret_arb;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned RETW  = 14;
`ifdef FPU_RET_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_ret_arb_if #(.RETW(RETW)) bus ();

    fpu_ret_arb #(
        .DEPTH (DEPTH),
        .RETW  (RETW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model state
    logic [RETW-1:0] mq [3][$];
    bit              m_vld;
    logic [RETW-1:0] m_data;
    int              m_port;
    int              m_last;
    bit [2:0]        m_ovf;
    bit [2:0]        m_stall;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) mq[i].delete();
        m_vld   = 1'b0;
        m_data  = '0;
        m_port  = 0;
        m_last  = 2;
        m_ovf   = '0;
        m_stall = '0;
    endfunction

    function automatic void model_step(input bit [2:0] en, input logic [RETW-1:0] d0,
                                       input logic [RETW-1:0] d1, input logic [RETW-1:0] d2,
                                       input bit rdy);
        logic [RETW-1:0] d [3];
        int  sz [3];
        bit  popped [3];
        bit  taken [3];
        int  g;
        d[0] = d0; d[1] = d1; d[2] = d2;
        for (int i = 0; i < 3; i++) begin
            sz[i] = mq[i].size();
            popped[i] = 1'b0;
            taken[i] = 1'b0;
        end
        if (!m_vld || rdy) begin
            g = -1;
            for (int k = 1; k <= 3; k++) begin
                int p;
                p = (m_last + k) % 3;
                if (g < 0 && (sz[p] > 0 || (BYP && en[p]))) g = p;
            end
            if (g >= 0) begin
                m_vld  = 1'b1;
                m_port = g;
                m_last = g;
                if (sz[g] > 0) begin
                    m_data = mq[g].pop_front();
                    popped[g] = 1'b1;
                end else begin
                    m_data = d[g];
                    taken[g] = 1'b1;
                end
            end else begin
                m_vld = 1'b0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (en[i] && !taken[i]) begin
                if (sz[i] < int'(DEPTH) || popped[i]) mq[i].push_back(d[i]);
                else m_ovf[i] = 1'b1;
            end
            m_stall[i] = (mq[i].size() >= int'(DEPTH) - 2);
        end
    endfunction

    task automatic compare();
        check("out_vld", 32'(bus.out_vld), 32'(m_vld));
        if (m_vld) begin
            check("out_data", 32'(bus.out_data), 32'(m_data));
            check("out_port", 32'(bus.out_port), 32'(m_port));
        end
        check("stall", 32'({bus.u5_stall, bus.u3_stall, bus.u1_stall}), 32'(m_stall));
        check("ovf", 32'(bus.ovf), 32'(m_ovf));
    endtask

    task automatic set_inputs(input bit [2:0] en, input logic [RETW-1:0] d0,
                              input logic [RETW-1:0] d1, input logic [RETW-1:0] d2,
                              input bit rdy);
        bus.u1_ret_en = en[0];
        bus.u3_ret_en = en[1];
        bus.u5_ret_en = en[2];
        bus.u1_ret    = d0;
        bus.u3_ret    = d1;
        bus.u5_ret    = d2;
        bus.out_rdy   = rdy;
    endtask

    // One clock: check registered outputs, apply inputs, advance the model.
    task automatic drive(input bit [2:0] en, input logic [RETW-1:0] d0,
                         input logic [RETW-1:0] d1, input logic [RETW-1:0] d2,
                         input bit rdy);
        @(negedge clk);
        compare();
        set_inputs(en, d0, d1, d2, rdy);
        model_step(en, d0, d1, d2, rdy);
        @(posedge clk);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(3'b000, '0, '0, '0, rdy);
    endtask

    initial begin
        rst = 1'b1;
        set_inputs(3'b000, '0, '0, '0, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare();

        // Single return from u1
        drive(3'b001, 14'h0A5, '0, '0, 1'b1);
        idle(4, 1'b1);

        // All three ports in one cycle
        drive(3'b111, 14'h001, 14'h002, 14'h003, 1'b1);
        idle(5, 1'b1);

        // u1 and u3 contending every cycle
        for (int i = 0; i < 8; i++) drive(3'b011, RETW'(16'h100 + i), RETW'(16'h200 + i), '0, 1'b1);
        idle(8, 1'b1);

        // Fill u5 while blocked, then pop and push together on the full FIFO
        for (int i = 0; i < 5; i++) drive(3'b100, '0, '0, RETW'(16'h500 + i), 1'b0);
        drive(3'b100, '0, '0, 14'h5AA, 1'b1);
        drive(3'b000, '0, '0, '0, 1'b0);
        idle(8, 1'b1);

        // Overflow u3 while blocked, then drain
        for (int i = 0; i < 6; i++) drive(3'b010, '0, RETW'(16'h300 + i), '0, 1'b0);
        idle(3, 1'b0);
        idle(8, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(3'($urandom), RETW'($urandom), RETW'($urandom), RETW'($urandom),
                  ($urandom_range(0, 3) != 0));
        end

        // Reset in the middle of buffered traffic
        for (int i = 0; i < 3; i++) drive(3'b111, RETW'($urandom), RETW'($urandom), RETW'($urandom), 1'b0);
        @(negedge clk);
        compare();
        rst = 1'b1;
        set_inputs(3'b000, '0, '0, '0, 1'b1);
        #1;
        check("rst_out_vld", 32'(bus.out_vld), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_stall", 32'({bus.u5_stall, bus.u3_stall, bus.u1_stall}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        idle(6, 1'b1);
        @(negedge clk);
        compare();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
